uart_mem_tx: RTL and testbench
==============================

Name: uart_mem_tx

Overview:
- Memory-reader / UART-transmitter counterpart to the team's UART receive path. The receive path writes received bytes into memory through we/address.
- On a start pulse, reads LENGTH bytes sequentially from a synchronous byte memory, beginning at base_addr.
- Serializes each byte onto a single 8N1 line: one start bit, 8 data bits LSB first, one stop bit.
- Sits between a byte-wide RAM read port and the serial tx pin. Dumps memory contents back out of the chip.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
ADDR_W, 32, width of memory address and length

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a transfer; ignored while busy=1
base_addr  input  ADDR_W  first memory address, sampled when start accepted
length  input  ADDR_W  byte count, sampled when start accepted
rd_en  output  1  memory read strobe
rd_addr  output  ADDR_W  memory read address
rd_data  input  8  memory read data, valid the cycle after rd_en=1
tx  output  1  serial line, idle high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the transfer completes

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, done=0, rd_en=0, rd_addr=0, state=IDLE, internal counters=0.
- Reset mid-frame aborts immediately:
  - tx returns high on the next edge.
  - No done pulse is generated.
- States and transitions:
  - IDLE: waits for start=1.
    - If length==0: go to FINISH.
    - Otherwise: latch base_addr and length, go to FETCH.
  - FETCH (1 cycle): rd_en=1, rd_addr=current address. Go to WAIT.
  - WAIT (1 cycle): rd_en=0. Latch rd_data into the shift register. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If bytes_sent+1 == length: go to FINISH.
    - Otherwise: increment the address, go to FETCH.
  - FINISH (1 cycle): done=1, busy=0. Go to IDLE.
- Timing (start accepted at edge k):
  - FETCH is cycle k+1.
  - tx falls at cycle k+3.
  - Each byte occupies 2 + 10*CLKS_PER_BIT cycles.
  - Total transfer time is length*(2+10*CLKS_PER_BIT) + 1 cycles.
- busy: 1 in every state except IDLE and FINISH.
- Address arithmetic: increments modulo 2^ADDR_W. Wraps from all-ones to 0 silently.
- length: treated as unsigned. length==0 produces a done pulse at k+1, with no rd_en and no tx activity.
- start asserted while busy=1, or in the FINISH cycle, is ignored and not queued.
- rd_addr holds its last value when rd_en=0.
- tx never glitches low outside the START and DATA states.

Test Plan:
- Single byte (CLKS_PER_BIT=4): mem[0x10]=0xA5, start with base_addr=0x10, length=1.
  -> rd_en for 1 cycle with rd_addr=0x10.
  -> tx waveform 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  -> done at cycle 43 after start; busy high in between.
- Burst of 3 (CLKS_PER_BIT=4): mem[0..2]=0x00,0xFF,0x3C.
  -> rd_addr sequence 0,1,2.
  -> Decoded bytes 0x00,0xFF,0x3C.
  -> Exactly 1 done pulse, 127 cycles after start.
- length=0 -> done high on the next cycle; rd_en and tx unchanged (0 and 1).
- Wrap-around: base_addr=0xFFFFFFFF, length=2 -> rd_addr 0xFFFFFFFF then 0x00000000; both bytes transmitted.
- start pulsed during byte 1 of a length=2 transfer -> ignored; exactly 2 frames and 1 done pulse.
- reset asserted in DATA state -> next cycle: tx=1, busy=0, done=0, rd_en=0. A subsequent start with length=1 transmits normally.

Source files
------------

// File: rtl/uart_mem_tx.sv
// uart_mem_tx: reads a block of bytes from a synchronous byte RAM and sends them out as 8N1 UART frames.
//   clk, reset          : system clock, synchronous active-high reset
//   start, base_addr,
//   length              : transfer request, address and length are captured when accepted
//   rd_en, rd_addr,
//   rd_data             : RAM read port, data returns the cycle after rd_en
//   tx                  : serial line, idle high
//   busy, done          : transfer in progress / one-cycle completion pulse
module uart_mem_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP, FINISH} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr, addr_n, len, len_n, sent, sent_n;
    logic [7:0] shift, shift_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic tx_reg, tx_n, bit_end;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            sent    <= '0;
            shift   <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_reg  <= 1'b1;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            len     <= len_n;
            sent    <= sent_n;
            shift   <= shift_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            tx_reg  <= tx_n;
        end
    end
    always_comb begin
        state_n = state;
        addr_n  = addr;
        len_n   = len;
        sent_n  = sent;
        shift_n = shift;
        bit_n   = bit_cnt;
        bit_end = cnt == CW'(CLKS_PER_BIT - 1);
        cnt_n   = (state == START || state == DATA || state == STOP) ? (bit_end ? '0 : cnt + CW'(1)) : '0;
        case (state)
            IDLE: if (start) begin
                if (length == '0) state_n = FINISH;
                else begin
                    addr_n  = base_addr;
                    len_n   = length;
                    sent_n  = '0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = WAIT;
            WAIT: begin
                shift_n = rd_data;
                state_n = START;
            end
            START: if (bit_end) begin
                bit_n   = '0;
                state_n = DATA;
            end
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                bit_n   = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = STOP;
            end
            STOP: if (bit_end) begin
                if (sent + ADDR_W'(1) == len) state_n = FINISH;
                else begin
                    sent_n  = sent + ADDR_W'(1);
                    addr_n  = addr + ADDR_W'(1);
                    state_n = FETCH;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // tx is registered from the next state so the pin is driven straight from a flop
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
    end
    always_comb begin
        rd_en   = state == FETCH;
        rd_addr = addr;
        tx      = tx_reg;
        busy    = state != IDLE && state != FINISH;
        done    = state == FINISH;
    end
endmodule

// File: tb/tb_uart_mem_tx.sv
// tb_uart_mem_tx: randomized self-checking bench for uart_mem_tx with a frame-level reference model.
module tb_uart_mem_tx;
    localparam int C = 4;
    localparam int FRAME = 2 + 10 * C;
    logic clk = 0, reset = 1, start = 0;
    logic [31:0] base_addr = 0, length = 0;
    logic rd_en, tx, busy, done;
    logic [31:0] rd_addr;
    logic [7:0] rd_data = 0;
    logic [7:0] mem [256];
    logic rec = 0;
    logic tx_q[$], busy_q[$], done_q[$];
    logic [31:0] addr_q[$];
    int tests = 0, fails = 0;

    uart_mem_tx #(.CLKS_PER_BIT(C), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[7:0]];

    always @(negedge clk) if (rec) begin
        tx_q.push_back(tx);
        busy_q.push_back(busy);
        done_q.push_back(done);
        if (rd_en) addr_q.push_back(rd_addr);
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    // Runs one transfer; sample index 0 is the cycle right after the accepting edge.
    task automatic run_xfer(input logic [31:0] base, input logic [31:0] len, input bit inject, input string name);
        int total, ndone, dpos, bad_busy, first_fall;
        logic [7:0] got[$];
        logic [31:0] a;
        logic [7:0] b;
        total = int'(len) * FRAME + 1;
        tx_q.delete(); busy_q.delete(); done_q.delete(); addr_q.delete();
        @(posedge clk); #1;
        start = 1; base_addr = base; length = len;
        @(posedge clk); #1;
        start = 0; base_addr = 32'($urandom); length = 32'($urandom_range(1, 3));
        rec = 1;
        for (int n = 0; n < total + 4; n++) begin
            @(posedge clk); #1;
            start = inject && n == FRAME / 2;
        end
        start = 0;
        @(negedge clk); #1;
        rec = 0;
        ndone = 0; dpos = -1; bad_busy = 0;
        for (int i = 0; i < done_q.size(); i++) begin
            if (done_q[i]) begin ndone++; if (dpos < 0) dpos = i; end
            if (busy_q[i] !== (i < total - 1)) bad_busy++;
        end
        tests++;
        if (ndone !== 1) begin fails++; $display("FAIL %s done_count got %0d want 1", name, ndone); end
        tests++;
        if (dpos !== total - 1) begin fails++; $display("FAIL %s done_cycle got %0d want %0d", name, dpos + 1, total); end
        tests++;
        if (bad_busy !== 0) begin fails++; $display("FAIL %s busy_window got %0d bad cycles want 0", name, bad_busy); end
        tests++;
        if (addr_q.size() !== int'(len)) begin fails++; $display("FAIL %s rd_count got %0d want %0d", name, addr_q.size(), len); end
        else for (int i = 0; i < addr_q.size(); i++) begin
            a = base + 32'(i);
            tests++;
            if (addr_q[i] !== a) begin fails++; $display("FAIL %s rd_addr[%0d] got %h want %h", name, i, addr_q[i], a); end
        end
        first_fall = -1;
        for (int j = 0; j < tx_q.size(); j++) begin
            if (tx_q[j] === 1'b0 && (j == 0 || tx_q[j-1] === 1'b1)) begin
                if (first_fall < 0) first_fall = j;
                if (j + 10 * C > tx_q.size()) break;
                b = 0;
                for (int i = 0; i < 8; i++) b[i] = tx_q[j + C * (1 + i) + C / 2];
                tests++;
                if (tx_q[j + 9 * C + C / 2] !== 1'b1) begin fails++; $display("FAIL %s stop_bit got 0 want 1", name); end
                got.push_back(b);
                j += 10 * C - 1;
            end
        end
        tests++;
        if (got.size() !== int'(len)) begin fails++; $display("FAIL %s frame_count got %0d want %0d", name, got.size(), len); end
        else for (int i = 0; i < got.size(); i++) begin
            a = base + 32'(i);
            tests++;
            if (got[i] !== mem[a[7:0]]) begin fails++; $display("FAIL %s byte[%0d] got %h want %h", name, i, got[i], mem[a[7:0]]); end
        end
        if (len != 0) begin
            tests++;
            if (first_fall !== 2) begin fails++; $display("FAIL %s first_tx_fall got %0d want 3", name, first_fall + 1); end
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({tx, busy, done, rd_en} !== 4'b1000 || rd_addr !== 32'h0) begin
            fails++; $display("FAIL reset_state got tx%b busy%b done%b rd_en%b addr%h want 1 0 0 0 0", tx, busy, done, rd_en, rd_addr);
        end
        reset = 0;
    endtask

    task automatic test_single();
        fill_mem();
        mem[8'h10] = 8'hA5;
        run_xfer(32'h10, 1, 0, "single");
    endtask

    task automatic test_burst();
        fill_mem();
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h3C;
        run_xfer(32'h0, 3, 0, "burst3");
    endtask

    task automatic test_zero_len();
        run_xfer(32'($urandom), 0, 0, "len0");
        tests++;
        if (tx_q.size() < 1 || tx_q.sum() with (int'(item)) !== tx_q.size()) begin
            fails++; $display("FAIL len0 tx_idle got activity want all ones");
        end
    endtask

    task automatic test_wrap();
        fill_mem();
        run_xfer(32'hFFFF_FFFF, 2, 0, "wrap");
    endtask

    task automatic test_ignore_start();
        fill_mem();
        run_xfer(32'($urandom), 2, 1, "busy_start");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            fill_mem();
            run_xfer((t % 2) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : 32'($urandom), 32'($urandom_range(1, 4)), 0, "random");
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        fill_mem();
        @(posedge clk); #1;
        start = 1; base_addr = 32'($urandom); length = 2;
        @(posedge clk); #1;
        start = 0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        tests++;
        if ({tx, busy, done, rd_en} !== 4'b1000) begin
            fails++; $display("FAIL reset_mid got tx%b busy%b done%b rd_en%b want 1 0 0 0", tx, busy, done, rd_en);
        end
        reset = 0;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (done || busy || !tx) seen++; end
        tests++;
        if (seen !== 0) begin fails++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen); end
        run_xfer(32'($urandom), 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_zero_len();
        test_wrap();
        test_ignore_start();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
